// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debouncer bank.
// The state encoding is chosen so that bit 0 set means a change is being qualified.
package debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      MAYBE_HI  = 2'b01,
      STABLE_HI = 2'b10,
      MAYBE_LO  = 2'b11
   } db_state_t;

   localparam int DEF_CNT_W       = 8;
   localparam int DEF_WINDOW      = 100;
   localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: synchroniser, four-state qualifier and window counter.
// All outputs are registered, so there is no combinational path from sw_in.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int WINDOW      = DEF_WINDOW,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter bit INIT_LEVEL  = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic sw_in,
   output logic sw_db,
   output logic rise,
   output logic fall,
   output logic in_maybe
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic [CNT_W-1:0]       cnt;
   db_state_t              state;

   always_ff @(posedge clk) begin
      if (rst) sync <= {SYNC_STAGES{INIT_LEVEL}};
      else     sync <= {sync[SYNC_STAGES-2:0], sw_in};
   end

   assign s = sync[SYNC_STAGES-1];

   // A reversal of s while qualifying wins over acceptance, even on a tick cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= INIT_LEVEL ? STABLE_HI : STABLE_LO;
         cnt      <= '0;
         sw_db    <= INIT_LEVEL;
         rise     <= 1'b0;
         fall     <= 1'b0;
         in_maybe <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            STABLE_LO: if (s) begin
               state    <= MAYBE_HI;
               cnt      <= '0;
               in_maybe <= 1'b1;
            end
            MAYBE_HI: begin
               if (!s) begin
                  state    <= STABLE_LO;
                  cnt      <= '0;
                  in_maybe <= 1'b0;
               end else if (tick && cnt == LAST) begin
                  state    <= STABLE_HI;
                  cnt      <= '0;
                  sw_db    <= 1'b1;
                  rise     <= 1'b1;
                  in_maybe <= 1'b0;
               end else if (tick) begin
                  cnt <= cnt + 1'b1;
               end
            end
            STABLE_HI: if (!s) begin
               state    <= MAYBE_LO;
               cnt      <= '0;
               in_maybe <= 1'b1;
            end
            MAYBE_LO: begin
               if (s) begin
                  state    <= STABLE_HI;
                  cnt      <= '0;
                  in_maybe <= 1'b0;
               end else if (tick && cnt == LAST) begin
                  state    <= STABLE_LO;
                  cnt      <= '0;
                  sw_db    <= 1'b0;
                  fall     <= 1'b1;
                  in_maybe <= 1'b0;
               end else if (tick) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state    <= STABLE_LO;
               cnt      <= '0;
               sw_db    <= 1'b0;
               in_maybe <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent switch debouncers sharing one clock and tick strobe.
// busy flags that at least one channel is still qualifying a change.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int N_CH        = 18,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int WINDOW      = DEF_WINDOW,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter bit INIT_LEVEL  = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick,
   input  logic [N_CH-1:0] sw_in,
   output logic [N_CH-1:0] sw_db,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic            busy
);

   if (WINDOW < 1 || WINDOW > (1 << CNT_W)) begin : g_bad_window
      $error("debounce_bank: WINDOW must lie in 1..2**CNT_W");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("debounce_bank: SYNC_STAGES must be at least 2");
   end

   logic [N_CH-1:0] in_maybe;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_chan #(
         .CNT_W      (CNT_W),
         .WINDOW     (WINDOW),
         .SYNC_STAGES(SYNC_STAGES),
         .INIT_LEVEL (INIT_LEVEL)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .tick    (tick),
         .sw_in   (sw_in[i]),
         .sw_db   (sw_db[i]),
         .rise    (rise[i]),
         .fall    (fall[i]),
         .in_maybe(in_maybe[i])
      );
   end

   // Each in_maybe is a flop, so busy is registered from next-state.
   assign busy = |in_maybe;

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised and directed bench for debounce_bank, checked against a
// tick-counting behavioural model of the acceptance rules.
module tb_debounce_bank;

   localparam int N  = 4;
   localparam int W  = 4;
   localparam int SS = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         tick = 1'b1;
   logic [N-1:0] sw_in = '0;
   logic [N-1:0] sw_db, rise, fall;
   logic         busy;

   logic [N-1:0] sw_in_p = '0;
   logic [N-1:0] db_w1, rise_w1, fall_w1, db_w256, rise_w256, fall_w256;
   logic         busy_w1, busy_w256;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   debounce_bank #(.N_CH(N), .CNT_W(8), .WINDOW(W), .SYNC_STAGES(SS), .INIT_LEVEL(1'b0)) dut (
      .clk(clk), .rst(rst), .tick(tick), .sw_in(sw_in),
      .sw_db(sw_db), .rise(rise), .fall(fall), .busy(busy));

   debounce_bank #(.N_CH(N), .CNT_W(8), .WINDOW(1), .SYNC_STAGES(SS), .INIT_LEVEL(1'b0)) dut_w1 (
      .clk(clk), .rst(rst), .tick(tick), .sw_in(sw_in_p),
      .sw_db(db_w1), .rise(rise_w1), .fall(fall_w1), .busy(busy_w1));

   debounce_bank #(.N_CH(N), .CNT_W(8), .WINDOW(256), .SYNC_STAGES(SS), .INIT_LEVEL(1'b0)) dut_w256 (
      .clk(clk), .rst(rst), .tick(tick), .sw_in(sw_in_p),
      .sw_db(db_w256), .rise(rise_w256), .fall(fall_w256), .busy(busy_w256));

   // Reference: the synchronised level is sw_in delayed by SS edges. A channel
   // whose synchronised level differs from its accepted level starts pending
   // (that edge is not counted); a return to the accepted level cancels it; the
   // W-th tick seen while still different accepts the new level with a pulse.
   logic [N-1:0] m_sync [SS];
   logic [N-1:0] m_db, m_rise, m_fall, m_pend;
   int           m_ticks [N];
   logic         m_busy;

   always @(posedge clk) begin
      logic [N-1:0] s;
      if (rst) begin
         for (int k = 0; k < SS; k++) m_sync[k] = '0;
         m_db = '0; m_rise = '0; m_fall = '0; m_pend = '0;
         for (int c = 0; c < N; c++) m_ticks[c] = 0;
      end else begin
         s = m_sync[SS-1];
         m_rise = '0; m_fall = '0;
         for (int c = 0; c < N; c++) begin
            if (!m_pend[c]) begin
               if (s[c] != m_db[c]) begin m_pend[c] = 1'b1; m_ticks[c] = 0; end
            end else if (s[c] == m_db[c]) begin
               m_pend[c] = 1'b0;
            end else if (tick) begin
               m_ticks[c] = m_ticks[c] + 1;
               if (m_ticks[c] == W) begin
                  m_db[c] = s[c]; m_pend[c] = 1'b0;
                  if (s[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
               end
            end
         end
         for (int k = SS-1; k > 0; k--) m_sync[k] = m_sync[k-1];
         m_sync[0] = sw_in;
      end
      m_busy = |m_pend;
   end

   task automatic go_idle();
      sw_in = '0; sw_in_p = '0; tick = 1'b1; rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; sw_in = 4'b1111; tick = 1'b1;
      for (int e = 1; e <= 2; e++) begin
         @(posedge clk); #1;
         total++;
         if ({sw_db, rise, fall, busy} !== 13'd0) begin
            bad++; $display("FAIL reset_hold e=%0d got db=%b r=%b f=%b busy=%b want all 0", e, sw_db, rise, fall, busy);
         end
      end
      rst = 1'b0;
      for (int e = 1; e <= 9; e++) begin
         @(posedge clk); #1;
         total++;
         if (e < 7 && (sw_db !== 4'b0000 || rise !== 4'b0000)) begin
            bad++; $display("FAIL reset_early e=%0d got db=%b rise=%b want 0000", e, sw_db, rise);
         end else if (e == 7 && (sw_db !== 4'b1111 || rise !== 4'b1111)) begin
            bad++; $display("FAIL reset_accept got db=%b rise=%b want 1111 1111", sw_db, rise);
         end else if (e > 7 && (sw_db !== 4'b1111 || rise !== 4'b0000)) begin
            bad++; $display("FAIL reset_pulse e=%0d got db=%b rise=%b want 1111 0000", e, sw_db, rise);
         end
      end
   endtask

   task automatic test_press();
      go_idle();
      sw_in = 4'b0001;
      for (int e = 1; e <= 10; e++) begin
         @(posedge clk); #1;
         total++;
         if ({sw_db, rise, fall, busy} !== {m_db, m_rise, m_fall, m_busy}) begin
            bad++; $display("FAIL press_model e=%0d got %b/%b/%b/%b want %b/%b/%b/%b", e, sw_db, rise, fall, busy, m_db, m_rise, m_fall, m_busy);
         end
         if (e == 2) begin total++; if (busy !== 1'b0) begin bad++; $display("FAIL press_busy_early got %b want 0", busy); end end
         if (e == 3) begin total++; if (busy !== 1'b1) begin bad++; $display("FAIL press_busy got %b want 1", busy); end end
         if (e == 6) begin total++; if (sw_db[0] !== 1'b0) begin bad++; $display("FAIL press_early got %b want 0", sw_db[0]); end end
         if (e == 7) begin total++; if ({sw_db[0], rise[0]} !== 2'b11) begin bad++; $display("FAIL press_accept got db=%b rise=%b want 1 1", sw_db[0], rise[0]); end end
         if (e == 8) begin total++; if (rise[0] !== 1'b0) begin bad++; $display("FAIL press_pulse_len got %b want 0", rise[0]); end end
      end
      sw_in = 4'b0000;
      for (int e = 1; e <= 10; e++) begin
         @(posedge clk); #1;
         if (e == 6) begin total++; if ({sw_db[0], fall[0]} !== 2'b10) begin bad++; $display("FAIL release_early got db=%b fall=%b want 1 0", sw_db[0], fall[0]); end end
         if (e == 7) begin total++; if ({sw_db[0], fall[0], rise[0]} !== 3'b010) begin bad++; $display("FAIL release_accept got db=%b fall=%b rise=%b want 0 1 0", sw_db[0], fall[0], rise[0]); end end
         if (e == 8) begin total++; if (fall[0] !== 1'b0) begin bad++; $display("FAIL release_pulse_len got %b want 0", fall[0]); end end
      end
   endtask

   task automatic test_bounce();
      logic seen;
      go_idle();
      seen = 1'b0;
      for (int c = 0; c < 24; c++) begin
         sw_in[1] = (c < 8) ? ~c[1] : 1'b0;
         @(posedge clk); #1;
         if (rise[1] || fall[1] || sw_db[1]) seen = 1'b1;
         total++;
         if ({sw_db, rise, fall, busy} !== {m_db, m_rise, m_fall, m_busy}) begin
            bad++; $display("FAIL bounce_model c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c, sw_db, rise, fall, busy, m_db, m_rise, m_fall, m_busy);
         end
      end
      total++;
      if (seen !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL bounce_reject got seen=%b busy=%b want 0 0", seen, busy);
      end
   endtask

   task automatic test_tick_gating();
      go_idle();
      for (int c = 0; c < 80; c++) begin
         tick = (c % 10 == 5);
         sw_in[2] = (c != 25);
         @(posedge clk); #1;
         total++;
         if ({sw_db, rise, fall, busy} !== {m_db, m_rise, m_fall, m_busy}) begin
            bad++; $display("FAIL tick_model c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c, sw_db, rise, fall, busy, m_db, m_rise, m_fall, m_busy);
         end
         if (c == 50 || c == 64) begin
            total++; if (sw_db[2] !== 1'b0) begin bad++; $display("FAIL tick_restart c=%0d got %b want 0", c, sw_db[2]); end
         end
         if (c == 65) begin
            total++; if ({sw_db[2], rise[2]} !== 2'b11) begin bad++; $display("FAIL tick_accept got db=%b rise=%b want 1 1", sw_db[2], rise[2]); end
         end
      end
      tick = 1'b1;
   endtask

   task automatic test_simultaneous();
      go_idle();
      sw_in = 4'b1000;
      repeat (10) @(posedge clk);
      #1 sw_in = 4'b0001;
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk); #1;
         if (e == 7) begin
            total++;
            if (rise !== 4'b0001 || fall !== 4'b1000 || sw_db !== 4'b0001) begin
               bad++; $display("FAIL simul got rise=%b fall=%b db=%b want 0001 1000 0001", rise, fall, sw_db);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      go_idle();
      sw_in = 4'b0001;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if (sw_db !== 4'b0000 || rise !== 4'b0000 || busy !== 1'b0) begin
         bad++; $display("FAIL reset_mid got db=%b rise=%b busy=%b want 0000 0000 0", sw_db, rise, busy);
      end
      sw_in = 4'b0000;
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk); #1;
         total++;
         if (rise !== 4'b0000 || sw_db !== 4'b0000) begin
            bad++; $display("FAIL reset_mid_after e=%0d got db=%b rise=%b want 0000 0000", e, sw_db, rise);
         end
      end
   endtask

   task automatic test_random();
      go_idle();
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 5) == 0) sw_in[$urandom_range(0, N-1)] ^= 1'b1;
         tick = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
         total++;
         if ({sw_db, rise, fall, busy} !== {m_db, m_rise, m_fall, m_busy}) begin
            bad++; $display("FAIL random_model c=%0d got %b/%b/%b/%b want %b/%b/%b/%b", c, sw_db, rise, fall, busy, m_db, m_rise, m_fall, m_busy);
         end
      end
      tick = 1'b1;
   endtask

   task automatic test_sweep();
      int e1, e256;
      go_idle();
      e1 = 0; e256 = 0;
      sw_in_p = 4'b0001;
      for (int e = 1; e <= 300; e++) begin
         @(posedge clk); #1;
         if (e1 == 0 && db_w1[0] === 1'b1) begin
            e1 = e;
            total++; if (rise_w1[0] !== 1'b1) begin bad++; $display("FAIL w1_rise got %b want 1", rise_w1[0]); end
         end
         if (e256 == 0 && db_w256[0] === 1'b1) begin
            e256 = e;
            total++; if (rise_w256[0] !== 1'b1) begin bad++; $display("FAIL w256_rise got %b want 1", rise_w256[0]); end
         end
      end
      total++;
      if (e1 != 4) begin bad++; $display("FAIL w1_latency got %0d want 4", e1); end
      total++;
      if (e256 != 259) begin bad++; $display("FAIL w256_latency got %0d want 259", e256); end
      total++;
      if (busy_w256 !== 1'b0 || db_w256 !== 4'b0001) begin
         bad++; $display("FAIL w256_final got busy=%b db=%b want 0 0001", busy_w256, db_w256);
      end
   endtask

   initial begin
      test_reset();
      test_press();
      test_bounce();
      test_tick_gating();
      test_simultaneous();
      test_reset_mid();
      test_random();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
